// File: rtl/kernel_pr_update_merge.sv
// PageRank update merge stage: pops {vid, val} words from the upstream FIFO, adds up
// consecutive contributions to the same vertex (at most MAX_RUN words per run) and
// pushes merged {vid, acc} words downstream. The EOS word follows the final update.
module kernel_pr_update_merge #(
    parameter int unsigned           VID_W   = 32,
    parameter int unsigned           VAL_W   = 32,
    parameter int unsigned           MAX_RUN = 16,
    parameter logic [VID_W-1:0]      EOS_VID = {VID_W{1'b1}}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_empty_n,
    input  logic [VID_W+VAL_W-1:0]   in_dout,
    output logic                     in_read,
    input  logic                     out_full_n,
    output logic [VID_W+VAL_W-1:0]   out_din,
    output logic                     out_write,
    output logic                     done,
    output logic [31:0]              upd_count
);

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    state_e                  state_q, state_d;
    logic [VID_W-1:0]        hold_vid_q;
    logic [VAL_W-1:0]        hold_acc_q;
    logic [7:0]              run_cnt_q;
    logic                    out_valid_q;
    logic [VID_W+VAL_W-1:0]  out_din_q;
    logic                    done_q;
    logic [31:0]             upd_count_q;

    logic [VID_W-1:0]        h_vid;
    logic [VAL_W-1:0]        h_val;
    logic                    eos;
    logic                    match;
    logic                    slot_free;

    // Decoded actions for this cycle
    logic                    hold_load;
    logic                    hold_add;
    logic                    out_load;
    logic                    out_from_hold;
    logic                    done_set;
    logic                    upd_inc;

    // Head word classification and output-slot availability
    always_comb begin
        h_vid     = in_dout[VID_W+VAL_W-1:VAL_W];
        h_val     = in_dout[VAL_W-1:0];
        eos       = (h_vid == EOS_VID);
        match     = (state_q == StAccum) && !eos && (h_vid == hold_vid_q) &&
                    (run_cnt_q < 8'(MAX_RUN));
        slot_free = !out_valid_q || out_full_n;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: hold becomes valid on a non-EOS pop, empties when EOS flushes it
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_empty_n && !eos) state_d = StAccum;
            end
            StAccum: begin
                if (in_empty_n && !match && eos && slot_free) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: pop request and datapath actions
    always_comb begin
        in_read       = 1'b0;
        hold_load     = 1'b0;
        hold_add      = 1'b0;
        out_load      = 1'b0;
        out_from_hold = 1'b0;
        done_set      = 1'b0;
        upd_inc       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_empty_n) begin
                    if (!eos) begin
                        // Filling an empty hold needs no output slot
                        in_read   = 1'b1;
                        hold_load = 1'b1;
                    end else if (slot_free) begin
                        in_read  = 1'b1;
                        out_load = 1'b1;
                        done_set = 1'b1;
                    end
                end
            end
            StAccum: begin
                if (in_empty_n) begin
                    if (match) begin
                        in_read  = 1'b1;
                        hold_add = 1'b1;
                    end else if (slot_free) begin
                        out_load      = 1'b1;
                        out_from_hold = 1'b1;
                        upd_inc       = 1'b1;
                        // EOS stays at the head and is popped later from idle
                        if (!eos) begin
                            in_read   = 1'b1;
                            hold_load = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Hold register: start a new run or accumulate into the current one
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_vid_q <= '0;
            hold_acc_q <= '0;
            run_cnt_q  <= '0;
        end else if (hold_load) begin
            hold_vid_q <= h_vid;
            hold_acc_q <= h_val;
            run_cnt_q  <= 8'd1;
        end else if (hold_add) begin
            hold_acc_q <= hold_acc_q + h_val;
            run_cnt_q  <= run_cnt_q + 8'd1;
        end
    end

    // Output register: a load may coincide with the transfer of the previous word
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_din_q   <= '0;
        end else if (out_load) begin
            out_valid_q <= 1'b1;
            out_din_q   <= out_from_hold ? {hold_vid_q, hold_acc_q} : in_dout;
        end else if (out_write) begin
            out_valid_q <= 1'b0;
        end
    end

    // Done pulse and update counter
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q      <= 1'b0;
            upd_count_q <= '0;
        end else begin
            done_q <= done_set;
            if (upd_inc) upd_count_q <= upd_count_q + 32'd1;
        end
    end

    // Output port drive
    always_comb begin
        out_write = out_valid_q && out_full_n;
        out_din   = out_din_q;
        done      = done_q;
        upd_count = upd_count_q;
    end

endmodule

// File: tb/tb_kernel_pr_update_merge.sv
// Bench for kernel_pr_update_merge: directed and random streams compared against a
// queue-based run-merging reference model.
module tb_kernel_pr_update_merge;

    localparam int unsigned MAX_RUN = 16;
    localparam logic [31:0] EOS     = 32'hFFFF_FFFF;

    typedef logic [63:0] word_t;

    logic        clk;
    logic        reset;
    logic        in_empty_n;
    word_t       in_dout;
    logic        in_read;
    logic        out_full_n;
    word_t       out_din;
    logic        out_write;
    logic        done;
    logic [31:0] upd_count;

    kernel_pr_update_merge #(
        .VID_W   (32),
        .VAL_W   (32),
        .MAX_RUN (MAX_RUN),
        .EOS_VID (EOS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_empty_n (in_empty_n),
        .in_dout    (in_dout),
        .in_read    (in_read),
        .out_full_n (out_full_n),
        .out_din    (out_din),
        .out_write  (out_write),
        .done       (done),
        .upd_count  (upd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks;
    int    n_errors;
    word_t stim_q[$];
    word_t exp_q[$];
    int    upd_model;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic word_t mk(input logic [31:0] vid, input logic [31:0] val);
        return {vid, val};
    endfunction

    // Reference: split the stream into runs of equal vid capped at MAX_RUN words,
    // sum each run, then pass EOS through after the last run.
    function automatic void build_expected();
        logic [31:0] cur;
        logic [31:0] acc;
        int          cnt;
        bit          have;
        exp_q.delete();
        have = 0;
        cur  = '0;
        acc  = '0;
        cnt  = 0;
        foreach (stim_q[i]) begin
            if (stim_q[i][63:32] == EOS) begin
                if (have) begin
                    exp_q.push_back(mk(cur, acc));
                    upd_model++;
                end
                exp_q.push_back(stim_q[i]);
                have = 0;
            end else if (have && stim_q[i][63:32] == cur && cnt < int'(MAX_RUN)) begin
                acc = acc + stim_q[i][31:0];
                cnt++;
            end else begin
                if (have) begin
                    exp_q.push_back(mk(cur, acc));
                    upd_model++;
                end
                cur  = stim_q[i][63:32];
                acc  = stim_q[i][31:0];
                cnt  = 1;
                have = 1;
            end
        end
    endfunction

    // Feed stim_q and collect outputs. bubble: 0 none, 1 alternate, 2 random.
    // full: 0 always ready, 1 random, 2 stalled for cycles 2..6 of the stream.
    // Called and returning at posedge+1.
    task automatic run_stream(input string name, input int bubble, input int full);
        word_t in_q[$];
        int    idx;
        int    dones;
        int    post;
        bit    eos_seen;
        bit    gate;
        in_q     = stim_q;
        build_expected();
        idx      = 0;
        dones    = 0;
        post     = 0;
        eos_seen = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            gate       = (bubble == 0) ? 1'b1 :
                         (bubble == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
            in_empty_n = (in_q.size() > 0) && gate;
            in_dout    = in_empty_n ? in_q[0] : {$urandom, $urandom};
            out_full_n = (full == 0) ? 1'b1 :
                         (full == 1) ? ($urandom_range(0, 2) != 0) : !(cyc >= 2 && cyc < 7);
            @(negedge clk);
            check({name, "_read_gated"}, 64'(in_read & ~in_empty_n), 64'd0);
            if (full == 2 && cyc >= 2 && cyc < 7) begin
                check({name, "_stall_read"}, 64'(in_read), 64'd0);
                check({name, "_stall_hold"}, out_din, mk(1, 1));
            end
            if (in_read && in_q.size() > 0) void'(in_q.pop_front());
            if (done) dones++;
            if (out_write) begin
                if (idx < exp_q.size())
                    check($sformatf("%s_out%0d", name, idx), out_din, exp_q[idx]);
                idx++;
                if (out_din[63:32] == EOS) eos_seen = 1;
            end
            @(posedge clk);
            #1;
            if (eos_seen) post++;
            if (post >= 3) break;
        end
        in_empty_n = 1'b0;
        out_full_n = 1'b1;
        check({name, "_eos_reached"}, 64'(eos_seen), 64'd1);
        check({name, "_out_count"}, 64'(idx), 64'(exp_q.size()));
        check({name, "_done_pulses"}, 64'(dones), 64'd1);
        check({name, "_upd_count"}, 64'(upd_count), 64'(upd_model));
        check({name, "_consumed"}, 64'(in_q.size()), 64'd0);
    endtask

    task automatic check_reset_values(input string name);
        @(negedge clk);
        check({name, "_in_read"}, 64'(in_read), 64'd0);
        check({name, "_out_write"}, 64'(out_write), 64'd0);
        check({name, "_out_din"}, out_din, 64'd0);
        check({name, "_done"}, 64'(done), 64'd0);
        check({name, "_upd_count"}, 64'(upd_count), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        upd_model  = 0;
        reset      = 1'b1;
        in_empty_n = 1'b0;
        in_dout    = '0;
        out_full_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_values("rst");

        // Basic merge
        stim_q = '{mk(5, 1), mk(5, 2), mk(5, 3), mk(7, 10), mk(EOS, 0)};
        run_stream("merge", 0, 0);

        // Run limit splits 20 equal-vid words into 16 + 4
        stim_q.delete();
        for (int i = 0; i < 20; i++) stim_q.push_back(mk(3, 1));
        stim_q.push_back(mk(EOS, 32'h1234));
        run_stream("runlim", 0, 0);

        // Downstream stall right after the first output loads
        stim_q = '{mk(1, 1), mk(2, 2), mk(3, 3), mk(EOS, 0)};
        run_stream("bp", 0, 2);

        // Accumulator wraps modulo 2^32
        stim_q = '{mk(9, 32'hFFFF_FFFF), mk(9, 2), mk(EOS, 0)};
        run_stream("wrap", 0, 0);

        // Input bubbles every other cycle
        stim_q = '{mk(4, 1), mk(4, 1), mk(6, 1), mk(EOS, 0)};
        run_stream("bubble", 1, 0);

        // Reset after two words are accepted discards the pending run
        in_empty_n = 1'b1;
        out_full_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_dout = mk(8, 5);
            @(negedge clk);
            check("midrst_accept", 64'(in_read), 64'd1);
            @(posedge clk);
            #1;
        end
        in_empty_n = 1'b0;
        reset      = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        upd_model = 0;
        check_reset_values("midrst");
        stim_q = '{mk(2, 1), mk(EOS, 0)};
        run_stream("midrst", 0, 0);

        // Random streams with random bubbles and backpressure
        for (int s = 0; s < 8; s++) begin
            int          len;
            logic [31:0] vid;
            stim_q.delete();
            len = $urandom_range(1, 60);
            vid = 32'd10;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) vid = 32'($urandom_range(10, 13));
                stim_q.push_back(mk(vid, $urandom));
            end
            stim_q.push_back(mk(EOS, $urandom));
            run_stream($sformatf("rand%0d", s), 2, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
